// File: rtl/match_eliminate.sv
// match_eliminate: clears every horizontal or vertical run of three or more
// equal non-empty cells on an 8x8 board, scanning one row/column per cycle.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   start        in   request; board is sampled when accepted in IDLE
//   board        in   192-bit board, cell (r,c) at [(r*8+c)*3 +: 3], 0 = empty
//   new_board    out  board with matched cells zeroed (held until next APPLY)
//   cleared_cnt  out  number of distinct cells cleared (0..64)
//   found        out  cleared_cnt != 0
//   busy         out  high from accept until the done cycle ends
//   done         out  one-cycle pulse, results valid from this cycle
//   score        out  accumulated cleared-cell score
//
// Build option: define MATCH_ELIM_SCORE_EN to build the saturating score
// accumulator; otherwise score is tied to zero.

module match_eliminate (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [191:0] board,
   output logic [191:0] new_board,
   output logic [6:0]   cleared_cnt,
   output logic         found,
   output logic         busy,
   output logic         done,
   output logic [15:0]  score
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ROW,
      S_COL,
      S_APPLY,
      S_DONE
   } state_t;

   state_t         r_state;
   state_t         w_next;
   logic [2:0]     r_idx;
   logic [191:0]   r_cur;
   logic [63:0]    r_mask;
   logic [191:0]   r_new_board;
   logic [6:0]     r_cnt;
   logic           r_found;
   logic           r_busy;
   logic           r_done;

   logic [2:0]     w_line [8];
   logic [5:0]     w_tri;
   logic [7:0]     w_run;
   logic [63:0]    w_mask_next;
   logic [191:0]   w_cleared;
   logic [6:0]     w_cnt;

   // Next-state logic
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (start) w_next = S_ROW;
         S_ROW:   if (r_idx == 3'd7) w_next = S_COL;
         S_COL:   if (r_idx == 3'd7) w_next = S_APPLY;
         S_APPLY: w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // The line under inspection: row r_idx in ROW, column r_idx otherwise.
   always_comb begin
      for (int k = 0; k < 8; k++) begin
         if (r_state == S_COL)
            w_line[k] = r_cur[(k*8 + int'(r_idx))*3 +: 3];
         else
            w_line[k] = r_cur[(int'(r_idx)*8 + k)*3 +: 3];
      end
   end

   // A run of length >= 3 is exactly the union of the equal,
   // non-empty triples it contains, so mark every triple's cells.
   always_comb begin
      w_tri = '0;
      w_run = '0;
      for (int j = 0; j < 6; j++) begin
         w_tri[j] = (w_line[j] != 3'd0) &&
                    (w_line[j] == w_line[j+1]) &&
                    (w_line[j+1] == w_line[j+2]);
      end
      for (int j = 0; j < 6; j++) begin
         w_run[j +: 3] = w_run[j +: 3] | {3{w_tri[j]}};
      end
   end

   // Fold this line's run bits into the board mask
   always_comb begin
      w_mask_next = r_mask;
      for (int k = 0; k < 8; k++) begin
         if (r_state == S_COL)
            w_mask_next[k*8 + int'(r_idx)] =
               w_mask_next[k*8 + int'(r_idx)] | w_run[k];
         else
            w_mask_next[int'(r_idx)*8 + k] =
               w_mask_next[int'(r_idx)*8 + k] | w_run[k];
      end
   end

   // Masked board and popcount; a cell hit by both a row and a
   // column run has a single mask bit, so it counts once.
   always_comb begin
      w_cleared = '0;
      w_cnt     = '0;
      for (int i = 0; i < 64; i++) begin
         w_cleared[i*3 +: 3] = r_mask[i] ? 3'd0 : r_cur[i*3 +: 3];
         w_cnt = w_cnt + {6'd0, r_mask[i]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_cur       <= '0;
         r_mask      <= '0;
         r_new_board <= '0;
         r_cnt       <= '0;
         r_found     <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state <= w_next;
         // Status flags are registered from the next state so they
         // line up with the state they describe.
         r_busy  <= (w_next != S_IDLE);
         r_done  <= (w_next == S_DONE);
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_cur  <= board;
                  r_mask <= '0;
                  r_idx  <= '0;
               end
            end
            S_ROW, S_COL: begin
               r_mask <= w_mask_next;
               // wraps 7 -> 0 on the ROW to COL hand-off
               r_idx  <= r_idx + 3'd1;
            end
            S_APPLY: begin
               r_new_board <= w_cleared;
               r_cnt       <= w_cnt;
               r_found     <= (w_cnt != 7'd0);
            end
            default: ;
         endcase
      end
   end

   assign new_board   = r_new_board;
   assign cleared_cnt = r_cnt;
   assign found       = r_found;
   assign busy        = r_busy;
   assign done        = r_done;

`ifdef MATCH_ELIM_SCORE_EN
   logic [15:0] r_score;
   logic [16:0] w_score_sum;

   assign w_score_sum = {1'b0, r_score} + {10'd0, w_cnt};

   always_ff @(posedge clk) begin
      if (rst)
         r_score <= '0;
      else if (r_state == S_APPLY)
         r_score <= w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
   end

   assign score = r_score;
`else
   assign score = '0;
`endif

endmodule

// File: tb/tb_match_eliminate.sv
// tb_match_eliminate: randomized and directed checks of match_eliminate
// against a run-length reference model of the match-3 clearing rule.

module tb_match_eliminate;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [191:0] board;
   logic [191:0] new_board;
   logic [6:0]   cleared_cnt;
   logic         found;
   logic         busy;
   logic         done;
   logic [15:0]  score;

   int errors = 0;
   int checks = 0;
   int exp_score = 0;

   match_eliminate dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .board       (board),
      .new_board   (new_board),
      .cleared_cnt (cleared_cnt),
      .found       (found),
      .busy        (busy),
      .done        (done),
      .score       (score)
   );

   always #5 clk = ~clk;

   function automatic logic [2:0] getc(input logic [191:0] b,
                                       input int r, input int c);
      return b[(r*8+c)*3 +: 3];
   endfunction

   function automatic logic [191:0] setc(input logic [191:0] b,
                                         input int r, input int c,
                                         input logic [2:0] v);
      logic [191:0] t;
      t = b;
      t[(r*8+c)*3 +: 3] = v;
      return t;
   endfunction

   function automatic logic [191:0] filler();
      logic [191:0] b;
      b = '0;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            b = setc(b, r, c, 3'(((r + 2*c) % 7) + 1));
      return b;
   endfunction

   // dir 0: line l is row l, position p is column; dir 1: transposed
   function automatic logic [2:0] cellat(input logic [191:0] b,
                                         input int dir, input int l,
                                         input int p);
      return (dir == 0) ? getc(b, l, p) : getc(b, p, l);
   endfunction

   // Reference: walk each line as maximal runs of equal values and
   // clear any non-empty run of length 3 or more.
   function automatic void model(input logic [191:0] b,
                                 output logic [191:0] nb,
                                 output int cnt);
      bit hit [8][8];
      int s;
      hit = '{default: '{default: 1'b0}};
      for (int dir = 0; dir < 2; dir++) begin
         for (int l = 0; l < 8; l++) begin
            s = 0;
            for (int p = 1; p <= 8; p++) begin
               bit brk;
               if (p == 8) brk = 1'b1;
               else brk = (cellat(b, dir, l, p) != cellat(b, dir, l, s));
               if (brk) begin
                  if (cellat(b, dir, l, s) != 3'd0 && (p - s) >= 3) begin
                     for (int q = s; q < p; q++) begin
                        if (dir == 0) hit[l][q] = 1'b1;
                        else hit[q][l] = 1'b1;
                     end
                  end
                  s = p;
               end
            end
         end
      end
      nb = b;
      cnt = 0;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            if (hit[r][c]) begin
               nb = setc(nb, r, c, 3'd0);
               cnt++;
            end
   endfunction

   function automatic int exp_sc();
`ifdef MATCH_ELIM_SCORE_EN
      return exp_score;
`else
      return 0;
`endif
   endfunction

   // Start one board and wait for done; lat = edges after accept, -1 on
   // timeout. Optionally re-pulses start (with alt) at edge pulse_at.
   task automatic run_board(input logic [191:0] b, input int pulse_at,
                            input logic [191:0] alt, output int lat);
      logic [191:0] nb;
      int c;
      int guard;
      guard = 0;
      while (busy && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      board = b;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         if (n == pulse_at) begin
            board = alt;
            start = 1'b1;
         end
         @(posedge clk); #1;
         start = 1'b0;
         if (done) begin
            lat = n;
            break;
         end
      end
      if (lat > 0) begin
         model(b, nb, c);
         exp_score = exp_score + c;
         if (exp_score > 65535) exp_score = 65535;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      board = {6{$urandom}};
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_score = 0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", done); end
      checks++; if (found !== 1'b0) begin errors++; $display("FAIL rst_found got=%b exp=0", found); end
      checks++; if (cleared_cnt !== 7'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", cleared_cnt); end
      checks++; if (new_board !== 192'd0) begin errors++; $display("FAIL rst_board got=%h exp=0", new_board); end
      checks++; if (score !== 16'd0) begin errors++; $display("FAIL rst_score got=%0d exp=0", score); end
   endtask

   task automatic test_zero();
      int lat;
      run_board('0, 0, '0, lat);
      checks++; if (lat !== 17) begin errors++; $display("FAIL zero_lat got=%0d exp=17", lat); end
      checks++; if (found !== 1'b0) begin errors++; $display("FAIL zero_found got=%b exp=0", found); end
      checks++; if (cleared_cnt !== 7'd0) begin errors++; $display("FAIL zero_cnt got=%0d exp=0", cleared_cnt); end
      checks++; if (new_board !== 192'd0) begin errors++; $display("FAIL zero_board got=%h exp=0", new_board); end
   endtask

   task automatic test_row3();
      logic [191:0] b;
      logic [191:0] nb;
      int c;
      int lat;
      b = filler();
      for (int k = 0; k < 3; k++) b = setc(b, 0, k, 3'd6);
      model(b, nb, c);
      run_board(b, 0, '0, lat);
      checks++; if (lat !== 17) begin errors++; $display("FAIL row3_lat got=%0d exp=17", lat); end
      checks++; if (cleared_cnt !== 7'd3) begin errors++; $display("FAIL row3_cnt got=%0d exp=3", cleared_cnt); end
      checks++; if (found !== 1'b1) begin errors++; $display("FAIL row3_found got=%b exp=1", found); end
      checks++; if (new_board !== nb) begin errors++; $display("FAIL row3_board got=%h exp=%h", new_board, nb); end
      checks++; if (score !== 16'(exp_sc())) begin errors++; $display("FAIL row3_score got=%0d exp=%0d", score, exp_sc()); end
   endtask

   function automatic logic [191:0] cross_board();
      logic [191:0] b;
      b = filler();
      for (int k = 2; k <= 4; k++) b = setc(b, 3, k, 3'd7);
      for (int k = 1; k <= 5; k++) b = setc(b, k, 3, 3'd7);
      return b;
   endfunction

   task automatic test_cross();
      logic [191:0] b;
      logic [191:0] nb;
      int c;
      int lat;
      b = cross_board();
      model(b, nb, c);
      run_board(b, 0, '0, lat);
      checks++; if (lat !== 17) begin errors++; $display("FAIL cross_lat got=%0d exp=17", lat); end
      checks++; if (cleared_cnt !== 7'(c)) begin errors++; $display("FAIL cross_cnt got=%0d exp=%0d", cleared_cnt, c); end
      checks++; if (getc(new_board, 3, 3) !== 3'd0) begin errors++; $display("FAIL cross_center got=%0d exp=0", getc(new_board, 3, 3)); end
      checks++; if (new_board !== nb) begin errors++; $display("FAIL cross_board got=%h exp=%h", new_board, nb); end
   endtask

   function automatic logic [191:0] rows_board();
      logic [191:0] b;
      b = '0;
      for (int r = 0; r < 8; r++)
         for (int k = 0; k < 8; k++)
            b = setc(b, r, k, 3'(r));
      return b;
   endfunction

   task automatic test_rows();
      int lat;
      run_board(rows_board(), 0, '0, lat);
      checks++; if (lat !== 17) begin errors++; $display("FAIL rows_lat got=%0d exp=17", lat); end
      checks++; if (cleared_cnt !== 7'd56) begin errors++; $display("FAIL rows_cnt got=%0d exp=56", cleared_cnt); end
      checks++; if (found !== 1'b1) begin errors++; $display("FAIL rows_found got=%b exp=1", found); end
      checks++; if (new_board !== 192'd0) begin errors++; $display("FAIL rows_board got=%h exp=0", new_board); end
   endtask

   task automatic test_ignore_start();
      logic [191:0] a;
      logic [191:0] nb;
      int c;
      int lat;
      a = cross_board();
      model(a, nb, c);
      run_board(a, 4, rows_board(), lat);
      checks++; if (lat !== 17) begin errors++; $display("FAIL ign_lat got=%0d exp=17", lat); end
      checks++; if (cleared_cnt !== 7'(c)) begin errors++; $display("FAIL ign_cnt got=%0d exp=%0d", cleared_cnt, c); end
      checks++; if (new_board !== nb) begin errors++; $display("FAIL ign_board got=%h exp=%h", new_board, nb); end
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_idle busy got=%b exp=0", busy); end
   endtask

   task automatic test_mid_reset();
      logic [191:0] b;
      int lat;
      bit saw;
      b = filler();
      for (int k = 0; k < 3; k++) b = setc(b, 0, k, 3'd6);
      board = cross_board();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_score = 0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_done got=%b exp=0", done); end
      checks++; if (new_board !== 192'd0) begin errors++; $display("FAIL mid_board got=%h exp=0", new_board); end
      checks++; if (cleared_cnt !== 7'd0) begin errors++; $display("FAIL mid_cnt got=%0d exp=0", cleared_cnt); end
      checks++; if (found !== 1'b0) begin errors++; $display("FAIL mid_found got=%b exp=0", found); end
      checks++; if (score !== 16'd0) begin errors++; $display("FAIL mid_score got=%0d exp=0", score); end
      saw = 1'b0;
      repeat (25) begin
         @(posedge clk); #1;
         if (done) saw = 1'b1;
      end
      checks++; if (saw !== 1'b0) begin errors++; $display("FAIL mid_nodone got=%b exp=0", saw); end
      run_board(b, 0, '0, lat);
      checks++; if (lat !== 17) begin errors++; $display("FAIL mid_relat got=%0d exp=17", lat); end
      checks++; if (cleared_cnt !== 7'd3) begin errors++; $display("FAIL mid_recnt got=%0d exp=3", cleared_cnt); end
   endtask

   task automatic test_random();
      logic [191:0] b;
      logic [191:0] nb;
      int c;
      int lat;
      for (int t = 0; t < 24; t++) begin
         b = '0;
         for (int i = 0; i < 64; i++)
            b[i*3 +: 3] = 3'($urandom_range(0, (t < 12) ? 2 : 7));
         model(b, nb, c);
         run_board(b, 0, '0, lat);
         checks++; if (lat !== 17) begin errors++; $display("FAIL rnd%0d_lat got=%0d exp=17", t, lat); end
         checks++; if (new_board !== nb) begin errors++; $display("FAIL rnd%0d_board got=%h exp=%h", t, new_board, nb); end
         checks++; if (cleared_cnt !== 7'(c)) begin errors++; $display("FAIL rnd%0d_cnt got=%0d exp=%0d", t, cleared_cnt, c); end
         checks++; if (found !== (c != 0)) begin errors++; $display("FAIL rnd%0d_found got=%b exp=%b", t, found, c != 0); end
         checks++; if (score !== 16'(exp_sc())) begin errors++; $display("FAIL rnd%0d_score got=%0d exp=%0d", t, score, exp_sc()); end
      end
   endtask

   task automatic test_back_to_back();
      logic [191:0] b;
      int lat1;
      int lat2;
      b = filler();
      for (int k = 0; k < 3; k++) b = setc(b, 0, k, 3'd6);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_score = 0;
      run_board(b, 0, '0, lat1);
      run_board(rows_board(), 0, '0, lat2);
      checks++; if (lat1 !== 17) begin errors++; $display("FAIL b2b_lat1 got=%0d exp=17", lat1); end
      checks++; if (lat2 !== 17) begin errors++; $display("FAIL b2b_lat2 got=%0d exp=17", lat2); end
      checks++; if (cleared_cnt !== 7'd56) begin errors++; $display("FAIL b2b_cnt got=%0d exp=56", cleared_cnt); end
`ifdef MATCH_ELIM_SCORE_EN
      checks++; if (score !== 16'd59) begin errors++; $display("FAIL b2b_score got=%0d exp=59", score); end
`else
      checks++; if (score !== 16'd0) begin errors++; $display("FAIL b2b_score got=%0d exp=0", score); end
`endif
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      board = '0;
      test_reset();
      test_zero();
      test_row3();
      test_cross();
      test_ignore_start();
      test_mid_reset();
      test_rows();
      test_random();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
